// File: rtl/score_digits_render.sv
// score_digits_render: multi-digit seven-segment pixel renderer with frame-synchronous BCD conversion and blink
module score_digits_render #(
    parameter int DIGITS       = 2,
    parameter int VALUE_W      = 7,
    parameter int SCALE        = 1,
    parameter int DIGIT_GAP    = 6,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [VALUE_W-1:0] value,
    input  logic               blink_en,
    input  logic [9:0]         origin_x,
    input  logic [9:0]         origin_y,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic               display,
    output logic               busy
);
    localparam int BW    = 4 * DIGITS;
    localparam int LIMIT = DIGITS == 1 ? 10 : DIGITS == 2 ? 100 : DIGITS == 3 ? 1000 : 10000;
    localparam int CW    = $clog2(VALUE_W + 1);
    localparam int FW    = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam int PITCH = (26 + DIGIT_GAP) * SCALE;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t             state, state_nx;
    logic [VALUE_W-1:0] bin;
    logic [BW-1:0]      bcd, bcd_adj, shown;
    logic               sat;
    logic [CW-1:0]      iter;
    logic [FW-1:0]      fcnt;
    logic               visible;
    logic [11:0]        xe, ye, dy;
    logic [11:0]        cell_x [DIGITS];
    logic [11:0]        dx [DIGITS];
    logic [DIGITS-1:0]  inx_c, in_x;
    logic               iny_c, in_y;
    logic [7:0]         rel_x [DIGITS];
    logic [7:0]         rel_y;
    logic               nz, hit;

    // Segment pattern {a,b,c,d,e,f,g}; codes above 9 never reach here
    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Scaled half-open range test on a cell-relative offset
    function automatic logic rng(input logic [7:0] v, input int lo, input int hi);
        return int'(v) >= lo * SCALE && int'(v) < hi * SCALE;
    endfunction

    function automatic logic seg_hit(input logic [3:0] d, input logic [7:0] rx, input logic [7:0] ry);
        logic [6:0] p;
        p = seg_pat(d);
        return (p[6] && rng(rx, 5, 21)  && rng(ry, 0, 4))
            || (p[5] && rng(rx, 22, 26) && rng(ry, 5, 17))
            || (p[4] && rng(rx, 22, 26) && rng(ry, 23, 35))
            || (p[3] && rng(rx, 5, 21)  && rng(ry, 36, 40))
            || (p[2] && rng(rx, 0, 4)   && rng(ry, 23, 35))
            || (p[1] && rng(rx, 0, 4)   && rng(ry, 5, 17))
            || (p[0] && rng(rx, 5, 21)  && rng(ry, 18, 22));
    endfunction

    // Conversion FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Conversion FSM next state: ticks outside IDLE are ignored
    always_comb begin
        state_nx = state == IDLE    ? (frame_tick ? CONVERT : IDLE)
                 : state == CONVERT ? (iter == CW'(VALUE_W - 1) ? COMMIT : CONVERT)
                 : IDLE;
    end

    // Conversion FSM output
    always_comb busy = state != IDLE;

    // Add-3 correction of every BCD nibble before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Capture, double-dabble iterations and commit to the shown digits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin   <= '0;
            bcd   <= '0;
            sat   <= 1'b0;
            iter  <= '0;
            shown <= '0;
        end else if (state == IDLE && frame_tick) begin
            bin  <= value;
            bcd  <= '0;
            sat  <= 32'(value) >= 32'(LIMIT);
            iter <= '0;
        end else if (state == CONVERT) begin
            bcd  <= {bcd_adj[BW-2:0], bin[VALUE_W-1]};
            bin  <= bin << 1;
            iter <= iter + 1'b1;
        end else if (state == COMMIT) begin
            shown <= sat ? {DIGITS{4'd9}} : bcd;
        end
    end

    // Blink frame counter and visibility toggle
    always_ff @(posedge clk or posedge reset) begin
        if (reset || !blink_en) begin
            fcnt    <= '0;
            visible <= 1'b1;
        end else if (frame_tick) begin
            fcnt    <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
            visible <= fcnt == FW'(BLINK_FRAMES - 1) ? ~visible : visible;
        end
    end

    // Per-digit offsets in 12 bits so far-right cells never wrap
    always_comb begin
        xe    = {2'b00, x};
        ye    = {2'b00, y};
        dy    = ye - {2'b00, origin_y};
        iny_c = ye >= {2'b00, origin_y} && dy < 12'(40 * SCALE);
        for (int k = 0; k < DIGITS; k++) begin
            cell_x[k] = {2'b00, origin_x} + 12'(k * PITCH);
            dx[k]     = xe - cell_x[k];
            inx_c[k]  = xe >= cell_x[k] && dx[k] < 12'(26 * SCALE);
        end
    end

    // Stage 1: register relative offsets and in-cell flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DIGITS; k++) rel_x[k] <= '0;
            rel_y <= '0;
            in_x  <= '0;
            in_y  <= 1'b0;
        end else begin
            for (int k = 0; k < DIGITS; k++) rel_x[k] <= dx[k][7:0];
            rel_y <= dy[7:0];
            in_x  <= inx_c;
            in_y  <= iny_c;
        end
    end

    // Segment hits with leading-zero blanking; rightmost digit always drawn
    always_comb begin
        nz  = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            nz  = nz | (shown[BW-1-4*k -: 4] != 4'd0);
            hit = hit | ((nz || k == DIGITS - 1) && in_x[k] && in_y
                         && seg_hit(shown[BW-1-4*k -: 4], rel_x[k], rel_y));
        end
    end

    // Stage 2: register the pixel, blanked while blink hides it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) display <= 1'b0;
        else       display <= visible & hit;
    end
endmodule
